regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 66 ++++++
 tb/tb_regfile_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with pending scoreboard, optional write-to-read bypass and one-cycle debug read port (clk/rst, write wen/waddr/wdata, reads raddrN->rdataN/rbusyN, pend_set/pend_addr->pend_err, dbg_req/dbg_addr->dbg_valid/dbg_data)
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  pend_set,
  input  logic [ADDR_WIDTH-1:0] pend_addr,
  output logic                  pend_err,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_data
);
  localparam int N = 2 ** ADDR_WIDTH;
  localparam bit BYP = BYPASS != 0;
  logic [DATA_WIDTH-1:0] rf_q [N];
  logic [N-1:0]          pend_q, pend_d;
  logic                  pend_err_q, pend_err_d;
  logic                  dbg_valid_q;
  logic [DATA_WIDTH-1:0] dbg_data_q;
  logic                  we, ps, hit1, hit2;
  assign we = wen && waddr != '0;
  assign ps = pend_set && pend_addr != '0;
  assign hit1 = BYP && we && waddr == raddr1;
  assign hit2 = BYP && we && waddr == raddr2;
  assign rdata1 = raddr1 == '0 ? '0 : hit1 ? wdata : rf_q[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : hit2 ? wdata : rf_q[raddr2];
  assign rbusy1 = raddr1 != '0 && pend_q[raddr1] && !hit1;
  assign rbusy2 = raddr2 != '0 && pend_q[raddr2] && !hit2;
  assign pend_err_d = ps && pend_q[pend_addr];
  assign pend_err = pend_err_q;
  assign dbg_valid = dbg_valid_q;
  assign dbg_data = dbg_data_q;
  always_comb begin
    pend_d = pend_q;
    if (we) pend_d[waddr] = 1'b0;
    if (ps) pend_d[pend_addr] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) rf_q[i] <= '0;
      pend_q      <= '0;
      pend_err_q  <= 1'b0;
      dbg_valid_q <= 1'b0;
      dbg_data_q  <= '0;
    end else begin
      if (we) rf_q[waddr] <= wdata;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
      dbg_valid_q <= dbg_req;
      if (dbg_req) dbg_data_q <= rf_q[dbg_addr];
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: random and directed checks of regfile_sb (bypass on and off) against an array-based reference model
module tb_regfile_sb;
  logic        clk = 1'b0, rst = 1'b1;
  logic        wen = 1'b0, pend_set = 1'b0, dbg_req = 1'b0;
  logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0, pend_addr = '0, dbg_addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1_a, rdata2_a, dbg_data_a, rdata1_b, rdata2_b, dbg_data_b;
  logic        rbusy1_a, rbusy2_a, pend_err_a, dbg_valid_a;
  logic        rbusy1_b, rbusy2_b, pend_err_b, dbg_valid_b;
  logic [31:0] mem [32];
  bit          pend [32];
  bit          e_err, e_dv;
  logic [31:0] e_dd;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_a), .rdata2(rdata2_a),
    .rbusy1(rbusy1_a), .rbusy2(rbusy2_a), .pend_set(pend_set), .pend_addr(pend_addr),
    .pend_err(pend_err_a), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_valid(dbg_valid_a), .dbg_data(dbg_data_a));

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
    .rbusy1(rbusy1_b), .rbusy2(rbusy2_b), .pend_set(pend_set), .pend_addr(pend_addr),
    .pend_err(pend_err_b), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_valid(dbg_valid_b), .dbg_data(dbg_data_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 0) return 32'h0;
    if (byp && wen && waddr == ra) return wdata;
    return mem[ra];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] ra, input bit byp);
    if (ra == 0) return 32'h0;
    if (byp && wen && waddr == ra) return 32'h0;
    return {31'h0, pend[ra]};
  endfunction

  task automatic model_reset();
    foreach (mem[i]) begin
      mem[i] = '0;
      pend[i] = 1'b0;
    end
    e_err = 1'b0;
    e_dv = 1'b0;
    e_dd = '0;
  endtask

  task automatic model_edge();
    e_err = pend_set && pend_addr != 0 && pend[pend_addr];
    e_dv = dbg_req;
    if (dbg_req) e_dd = mem[dbg_addr];
    if (wen && waddr != 0) begin
      mem[waddr] = wdata;
      pend[waddr] = 1'b0;
    end
    if (pend_set && pend_addr != 0) pend[pend_addr] = 1'b1;
  endtask

  task automatic check_comb();
    chk("rdata1_byp1", rdata1_a, exp_rd(raddr1, 1'b1));
    chk("rdata2_byp1", rdata2_a, exp_rd(raddr2, 1'b1));
    chk("rbusy1_byp1", {31'h0, rbusy1_a}, exp_busy(raddr1, 1'b1));
    chk("rbusy2_byp1", {31'h0, rbusy2_a}, exp_busy(raddr2, 1'b1));
    chk("rdata1_byp0", rdata1_b, exp_rd(raddr1, 1'b0));
    chk("rdata2_byp0", rdata2_b, exp_rd(raddr2, 1'b0));
    chk("rbusy1_byp0", {31'h0, rbusy1_b}, exp_busy(raddr1, 1'b0));
    chk("rbusy2_byp0", {31'h0, rbusy2_b}, exp_busy(raddr2, 1'b0));
  endtask

  task automatic check_reg();
    chk("pend_err_byp1", {31'h0, pend_err_a}, {31'h0, e_err});
    chk("dbg_valid_byp1", {31'h0, dbg_valid_a}, {31'h0, e_dv});
    chk("dbg_data_byp1", dbg_data_a, e_dd);
    chk("pend_err_byp0", {31'h0, pend_err_b}, {31'h0, e_err});
    chk("dbg_valid_byp0", {31'h0, dbg_valid_b}, {31'h0, e_dv});
    chk("dbg_data_byp0", dbg_data_b, e_dd);
  endtask

  task automatic step();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_reg();
  endtask

  task automatic idle();
    wen = 1'b0;
    pend_set = 1'b0;
    dbg_req = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 check_comb();
    check_reg();
    #11 rst = 1'b0;
    wen = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    step();
    wen = 1'b1; waddr = 0; wdata = 32'h1; raddr1 = 5; raddr2 = 0;
    step();
    chk("x5_lit", rdata1_a, 32'hDEADBEEF);
    chk("x0_lit", rdata2_a, 32'h0);
    wen = 1'b1; waddr = 7; wdata = 32'h55; raddr1 = 7;
    #1 chk("byp1_same_cycle", rdata1_a, 32'h55);
    chk("byp0_old_value", rdata1_b, 32'h0);
    step();
    idle();
    #1 chk("byp0_next_cycle", rdata1_b, 32'h55);
    step();
    pend_set = 1'b1; pend_addr = 3;
    step();
    idle(); raddr1 = 3;
    step();
    chk("busy_x3_lit", {31'h0, rbusy1_a}, 32'h1);
    wen = 1'b1; waddr = 3; wdata = 32'h9;
    step();
    idle();
    step();
    chk("x3_after_write", rdata1_a, 32'h9);
    pend_set = 1'b1; pend_addr = 4; wen = 1'b1; waddr = 4; wdata = 32'h44; raddr2 = 4;
    step();
    idle(); pend_set = 1'b1; pend_addr = 4;
    step();
    chk("pend_err_lit", {31'h0, pend_err_a}, 32'h1);
    idle();
    step();
    dbg_req = 1'b1; dbg_addr = 5; wen = 1'b1; waddr = 5; wdata = 32'hA;
    step();
    chk("dbg_old_lit", dbg_data_a, 32'hDEADBEEF);
    wen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      dbg_addr = 5'(i + 2);
      step();
    end
    idle();
    step();
    for (int i = 0; i < 400; i++) begin
      wen = 1'($urandom);
      waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wdata = $urandom;
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom);
      pend_set = 1'($urandom);
      pend_addr = 5'($urandom_range(0, 7));
      dbg_req = 1'($urandom);
      dbg_addr = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    wen = 1'b1; waddr = 5; wdata = 32'h1234; pend_set = 1'b1; pend_addr = 3;
    step();
    idle(); dbg_req = 1'b1; dbg_addr = 5;
    step();
    idle(); raddr1 = 5; raddr2 = 3;
    #3 rst = 1'b1;
    model_reset();
    #1 check_comb();
    check_reg();
    chk("rst_rdata1_lit", rdata1_a, 32'h0);
    @(negedge clk);
    wen = 1'b1; waddr = 5; wdata = 32'h77;
    rst = 1'b0;
    step();
    idle();
    #1 chk("first_write_after_rst", rdata1_a, 32'h77);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
